// File: rtl/key_event_fifo_pkg.sv
// key_pkg: shared widths, idle vector, event entry type and priority helper
// for the key event queue (release events selected by KEY_RELEASE_EVT_EN).
package key_pkg;

  localparam int unsigned KEY_W     = 16;
  localparam int unsigned KEY_IDX_W = 4;

  // Scanner vector is active-low: all ones means no key is down.
  localparam logic [KEY_W-1:0] KEY_IDLE = 16'hffff;

  // One queued event: rel=1 marks a release, code is the key index.
  typedef struct packed {
    logic                 rel;
    logic [KEY_IDX_W-1:0] code;
  } key_evt_t;

  localparam int unsigned KEY_EVT_W = $bits(key_evt_t);

  // Index of the lowest set bit; lower keys win arbitration.
  function automatic logic [KEY_IDX_W-1:0] lowest_set_idx(input logic [KEY_W-1:0] vec);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(KEY_W) - 1; i >= 0; i--) begin
      if (vec[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_fifo_if.sv
// key_event_fifo_if: valid/ready event stream toward the consumer.
interface key_event_fifo_if;
  import key_pkg::*;

  logic                 key_valid;
  logic                 key_ready;
  logic [KEY_IDX_W-1:0] key_code;
  logic                 key_rel;

  // Event producer (the key FIFO).
  modport master (
    output key_valid,
    output key_code,
    output key_rel,
    input  key_ready
  );

  // Event consumer (UART/display/CPU bridge).
  modport slave (
    input  key_valid,
    input  key_code,
    input  key_rel,
    output key_ready
  );
endinterface

// File: rtl/key_event_fifo_sync_fifo.sv
// key_evt_sync_fifo: single-clock FIFO, power-of-2 depth, extra-MSB pointers.
// Head is read straight from storage; a push into an empty FIFO shows up
// on the following cycle (no bypass).
module key_evt_sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en_c;
  logic             pop_en_c;

  // Same index with differing wrap bit means full; identical pointers mean empty.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Pop on empty is dropped; a full FIFO accepts a push when it pops too.
  assign pop_en_c  = pop & ~empty_c;
  assign push_en_c = push & (~full_c | pop_en_c);

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en_c) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en_c)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_en_c) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head_c = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/key_event_fifo.sv
// key_event_fifo: synchronises and debounces the 4x4 scanner vector, turns
// newly pressed keys into 4-bit codes and queues them for the consumer.
// Build option KEY_RELEASE_EVT_EN: also queue release events (key_rel=1),
// drained only after all pending presses.
module key_event_fifo
  import key_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 10,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_state,
  input  logic             clr_ovf,
  key_event_fifo_if.master bus,
  output logic [KEY_W-1:0] key_held,
  output logic             ovf
);

  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned SCNT_W = $clog2(STABLE_CNT);
`ifdef KEY_RELEASE_EVT_EN
  localparam int unsigned EVT_W  = KEY_EVT_W;
`else
  localparam int unsigned EVT_W  = KEY_IDX_W;
`endif

  logic [KEY_W-1:0]     sync1_q;
  logic [KEY_W-1:0]     sync2_q;
  logic [DIV_W-1:0]     div_q;
  logic                 tick_c;
  logic [KEY_W-1:0]     cand_q;
  logic [KEY_W-1:0]     cand_d;
  logic [SCNT_W-1:0]    scnt_q;
  logic [SCNT_W-1:0]    scnt_d;
  logic                 commit_c;
  logic [KEY_W-1:0]     press_mask_c;
  logic [KEY_W-1:0]     pend_p_q;
  logic [KEY_W-1:0]     pend_p_d;
  logic                 ovf_set_c;
  logic                 ovf_d;
  logic                 pop_c;
  logic                 slot_c;
  logic                 push_c;
  logic [KEY_IDX_W-1:0] push_idx_c;
  logic [EVT_W-1:0]     push_data_c;
  logic [EVT_W-1:0]     head_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;
`ifdef KEY_RELEASE_EVT_EN
  logic [KEY_W-1:0]     rel_mask_c;
  logic [KEY_W-1:0]     pend_r_q;
  logic [KEY_W-1:0]     pend_r_d;
  key_evt_t             head_evt_c;
`endif

  // Two-flop synchroniser; resets to the idle (all released) vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= KEY_IDLE;
      sync2_q <= KEY_IDLE;
    end else begin
      sync1_q <= key_state;
      sync2_q <= sync1_q;
    end
  end

  // Sample divider: one-cycle tick every SAMPLE_DIV clocks.
  assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + 1'b1;
  end

  // Debounce: a changed sample restarts the count; the vector commits once
  // the count has saturated, and keeps committing while unchanged.
  always_comb begin
    cand_d   = cand_q;
    scnt_d   = scnt_q;
    commit_c = 1'b0;
    if (tick_c) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        scnt_d = '0;
      end else if (scnt_q == SCNT_W'(STABLE_CNT - 1)) begin
        commit_c = 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  // Debounce state and committed vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= KEY_IDLE;
      scnt_q   <= '0;
      key_held <= KEY_IDLE;
    end else begin
      cand_q <= cand_d;
      scnt_q <= scnt_d;
      if (commit_c) key_held <= cand_q;
    end
  end

  // New presses are bits going 1->0 relative to the committed vector.
  assign press_mask_c = commit_c ? (key_held & ~cand_q) : '0;
`ifdef KEY_RELEASE_EVT_EN
  assign rel_mask_c   = commit_c ? (~key_held & cand_q) : '0;
`endif

  // A push slot exists when not full, or when the head leaves this cycle.
  assign pop_c  = ~fifo_empty_c & bus.key_ready;
  assign slot_c = ~fifo_full_c | pop_c;

  // Drain one pending event per cycle (presses first, lowest index first)
  // and merge this cycle's commit; a merge onto a set bit loses an event.
  always_comb begin
    push_c      = 1'b0;
    push_idx_c  = '0;
    push_data_c = '0;
    pend_p_d    = pend_p_q;
`ifdef KEY_RELEASE_EVT_EN
    pend_r_d    = pend_r_q;
`endif
    if (slot_c && (pend_p_q != '0)) begin
      push_c               = 1'b1;
      push_idx_c           = lowest_set_idx(pend_p_q);
      pend_p_d[push_idx_c] = 1'b0;
`ifdef KEY_RELEASE_EVT_EN
      push_data_c          = key_evt_t'{rel: 1'b0, code: push_idx_c};
`else
      push_data_c          = EVT_W'(push_idx_c);
`endif
    end
`ifdef KEY_RELEASE_EVT_EN
    else if (slot_c && (pend_r_q != '0)) begin
      push_c               = 1'b1;
      push_idx_c           = lowest_set_idx(pend_r_q);
      pend_r_d[push_idx_c] = 1'b0;
      push_data_c          = key_evt_t'{rel: 1'b1, code: push_idx_c};
    end
`endif
    pend_p_d  = pend_p_d | press_mask_c;
    ovf_set_c = |(press_mask_c & pend_p_q);
`ifdef KEY_RELEASE_EVT_EN
    pend_r_d  = pend_r_d | rel_mask_c;
    ovf_set_c = ovf_set_c | (|(rel_mask_c & pend_r_q));
`endif
    // Loss beats a same-cycle clear so no overflow goes unreported.
    if (ovf_set_c)    ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf;
  end

  // Pending event masks and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p_q <= '0;
`ifdef KEY_RELEASE_EVT_EN
      pend_r_q <= '0;
`endif
      ovf      <= 1'b0;
    end else begin
      pend_p_q <= pend_p_d;
`ifdef KEY_RELEASE_EVT_EN
      pend_r_q <= pend_r_d;
`endif
      ovf      <= ovf_d;
    end
  end

  key_evt_sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .head_c    (head_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  // Head of queue presented to the consumer.
  assign bus.key_valid = ~fifo_empty_c;
`ifdef KEY_RELEASE_EVT_EN
  assign head_evt_c    = key_evt_t'(head_c);
  assign bus.key_code  = head_evt_c.code;
  assign bus.key_rel   = head_evt_c.rel;
`else
  assign bus.key_code  = head_c;
  assign bus.key_rel   = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_fifo.sv
// tb_key_event_fifo: directed scenarios plus random key traffic, compared
// every cycle against a behavioural model of the key event queue.
module tb_key_event_fifo;
  import key_pkg::*;

  localparam int unsigned DIV = 10;
  localparam int unsigned STB = 4;
  localparam int unsigned DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_state;
  logic        clr_ovf;
  logic [15:0] key_held;
  logic        ovf;

  key_event_fifo_if bus ();

  key_event_fifo #(
    .SAMPLE_DIV (DIV),
    .STABLE_CNT (STB),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_state (key_state),
    .clr_ovf   (clr_ovf),
    .bus       (bus),
    .key_held  (key_held),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model state: synchroniser stages, run of identical samples, committed
  // vector, pending masks, sticky flag and the queue of {rel,code}.
  logic [15:0] m_s1, m_s2, m_last, m_held, m_pp;
  logic [4:0]  m_q[$];
  logic        m_ovf;
  int          m_run;
  int unsigned m_edges;
`ifdef KEY_RELEASE_EVT_EN
  logic [15:0] m_pr;
`endif
  logic [3:0]  got_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] low_idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_s1 = 16'hffff; m_s2 = 16'hffff; m_last = 16'hffff; m_held = 16'hffff;
    m_pp = '0; m_ovf = 1'b0; m_run = 1; m_edges = 0;
    m_q.delete();
`ifdef KEY_RELEASE_EVT_EN
    m_pr = '0;
`endif
  endtask

  // One clock edge of the reference behaviour, given this cycle's inputs.
  task automatic model_adv(input logic [15:0] ks, input logic rdy, input logic clr);
    logic        pop, slot, push, set;
    logic [4:0]  ev;
    logic [3:0]  idx;
    logic [15:0] pp_n, pm;
`ifdef KEY_RELEASE_EVT_EN
    logic [15:0] pr_n, rm;
    pr_n = m_pr; rm = '0;
`endif
    pop  = (m_q.size() > 0) && rdy;
    slot = (m_q.size() < int'(DEP)) || pop;
    push = 1'b0; ev = '0; pp_n = m_pp; pm = '0;
    if (slot && m_pp != 0) begin
      idx = low_idx(m_pp); push = 1'b1; ev = {1'b0, idx}; pp_n[idx] = 1'b0;
    end
`ifdef KEY_RELEASE_EVT_EN
    else if (slot && m_pr != 0) begin
      idx = low_idx(m_pr); push = 1'b1; ev = {1'b1, idx}; pr_n[idx] = 1'b0;
    end
`endif
    // Samples every DIV clocks; reset counts as one idle sample. Commit when
    // the current and the previous STB samples agree.
    m_edges++;
    if (m_edges % DIV == 0) begin
      if (m_s2 == m_last) m_run++;
      else begin m_run = 1; m_last = m_s2; end
      if (m_run >= int'(STB) + 1) begin
        pm = m_held & ~m_s2;
`ifdef KEY_RELEASE_EVT_EN
        rm = ~m_held & m_s2;
`endif
        m_held = m_s2;
      end
    end
    set = |(pm & m_pp);
    m_pp = pp_n | pm;
`ifdef KEY_RELEASE_EVT_EN
    set = set | (|(rm & m_pr));
    m_pr = pr_n | rm;
`endif
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(ev);
    m_s2 = m_s1; m_s1 = ks;
  endtask

  task automatic cmp_outputs();
    chk("valid", 32'(bus.key_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("code", 32'(bus.key_code), 32'(m_q[0][3:0]));
      chk("rel", 32'(bus.key_rel), 32'(m_q[0][4]));
    end
    chk("held", 32'(key_held), 32'(m_held));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // Called just after a falling edge: check, drive, advance model, next cycle.
  task automatic step(input logic [15:0] ks, input logic rdy, input logic clr);
    cmp_outputs();
    key_state = ks; bus.key_ready = rdy; clr_ovf = clr;
    if (bus.key_valid && rdy) got_log.push_back(bus.key_code);
    model_adv(ks, rdy, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] ks, input logic rdy, input int n);
    for (int c = 0; c < n; c++) step(ks, rdy, 1'b0);
  endtask

  task automatic tap(input int k, input logic rdy);
    hold(~(16'h0001 << k), rdy, 70);
    hold(16'hffff, rdy, 70);
  endtask

  task automatic chk_log(input string tag, input logic [3:0] exp[$]);
    chk({tag, "_count"}, 32'(got_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_log.size(); i++)
      chk({tag, "_code"}, 32'(got_log[i]), 32'(exp[i]));
  endtask

  int          lat;
  int          run_v;
  int          max_run;
  int          dur;
  logic [15:0] ks;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; key_state = 16'hffff; clr_ovf = 1'b0; bus.key_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.key_valid), 32'd0);
    chk("rst_code", 32'(bus.key_code), 32'd0);
    chk("rst_rel", 32'(bus.key_rel), 32'd0);
    chk("rst_held", 32'(key_held), 32'hffff);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Scenario 1: key 5 held steady.
    got_log.delete(); lat = -1;
    for (int c = 0; c < 80; c++) begin
      if (bus.key_valid && lat < 0) lat = c;
      step(16'hffdf, 1'b1, 1'b0);
    end
    chk("s1_latency", 32'(lat >= 0 && lat <= int'(DIV * (STB + 1) + 4)), 32'd1);
    chk_log("s1", '{4'd5});
    chk("s1_held", 32'(key_held), 32'hffdf);
    hold(16'hffff, 1'b1, 70);

    // Scenario 2: bit 3 chatters, then settles released.
    got_log.delete();
    for (int c = 0; c < 60; c++) step(((c / 7) % 2 == 0) ? 16'hfff7 : 16'hffff, 1'b1, 1'b0);
    hold(16'hffff, 1'b1, 80);
    chk_log("s2", '{});
    chk("s2_held", 32'(key_held), 32'hffff);

    // Scenario 3: keys 0 and 15 together.
    got_log.delete(); run_v = 0; max_run = 0;
    for (int c = 0; c < 80; c++) begin
      run_v = bus.key_valid ? run_v + 1 : 0;
      if (run_v > max_run) max_run = run_v;
      step(16'h7ffe, 1'b1, 1'b0);
    end
    chk_log("s3", '{4'd0, 4'd15});
    chk("s3_valid_run", 32'(max_run), 32'd2);
    hold(16'hffff, 1'b1, 70);

    // Scenario 4: five taps with the consumer stalled, then drain.
    got_log.delete();
    for (int k = 1; k <= 5; k++) tap(k, 1'b0);
    chk("s4_stalled_valid", 32'(bus.key_valid), 32'd1);
    hold(16'hffff, 1'b1, 40);
`ifndef KEY_RELEASE_EVT_EN
    chk_log("s4", '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
    chk("s4_ovf", 32'(ovf), 32'd0);
`endif

    // Scenario 5: full FIFO, key 9 pending, then re-pressed.
    got_log.delete();
    for (int k = 1; k <= 4; k++) tap(k, 1'b0);
    hold(16'hfdff, 1'b0, 70);
    hold(16'hffff, 1'b0, 70);
    hold(16'hfdff, 1'b0, 70);
`ifndef KEY_RELEASE_EVT_EN
    chk("s5_ovf_set", 32'(ovf), 32'd1);
`endif
    hold(16'hfdff, 1'b1, 40);
`ifndef KEY_RELEASE_EVT_EN
    chk_log("s5", '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9});
`endif
    step(16'hfdff, 1'b1, 1'b1);
    chk("s5_ovf_clr", 32'(ovf), 32'd0);
    hold(16'hffff, 1'b1, 70);

    // Scenario 6: asynchronous reset with events queued and a key held.
    tap(1, 1'b0);
    tap(2, 1'b0);
    hold(16'hfff7, 1'b0, 70);
    chk("s6_pre_valid", 32'(bus.key_valid), 32'd1);
    #2;
    rst_n = 1'b0; key_state = 16'hffff;
    #1;
    chk("s6_async_valid", 32'(bus.key_valid), 32'd0);
    chk("s6_async_held", 32'(key_held), 32'hffff);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_log.delete();
    hold(16'hffff, 1'b1, 100);
    chk_log("s6", '{});
    chk("s6_held", 32'(key_held), 32'hffff);

    // Random key traffic with random backpressure and clear pulses.
    ks = 16'hffff;
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 3))
        0: ks = 16'hffff;
        1: ks = ~(16'h0001 << $urandom_range(0, 15));
        2: ks = 16'($urandom) | 16'($urandom) | 16'($urandom);
        default: ks = ks;
      endcase
      dur = int'($urandom_range(5, 90));
      for (int c = 0; c < dur; c++)
        step(ks, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    hold(16'hffff, 1'b1, 150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
